hazard_scheduler: RTL and testbench

//  Central pipeline scheduler for the 5-stage RV32I core. Drives the stall/flush (CLR) controls of
//  the F/D, D/E, E/M and M/W pipeline registers and the E-stage forwarding muxes. Resolves load-use
//  and control hazards, and sequences the data-memory wait handshake (with timeout) via an FSM.

---
 rtl/hazard_scheduler_if.sv | 30 +++
 rtl/hazard_scheduler.sv | 106 ++++++++++
 tb/tb_hazard_scheduler.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/hazard_scheduler_if.sv
// Pipeline-side view of the hazard scheduler: register indices and hazard sources in,
// stall/flush/forward controls and memory status out.
interface hazard_scheduler_if #(
    parameter int AW = 5,
    parameter int CW = 32
);
    logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic          RegWriteM, RegWriteW;
    logic [1:0]    ResultSrcE;
    logic          PCSrcE, DMemReq, DMemReady;
    logic          StallF, StallD, StallE, StallM;
    logic          FlushD, FlushE, FlushW;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          MemTimeout;
    logic [CW-1:0] StallCycles;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
               ResultSrcE, PCSrcE, DMemReq, DMemReady,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               ForwardAE, ForwardBE, MemTimeout, StallCycles
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
               ResultSrcE, PCSrcE, DMemReq, DMemReady,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               ForwardAE, ForwardBE, MemTimeout, StallCycles
    );
endinterface

// File: rtl/hazard_scheduler.sv
// 5-stage RV32I hazard scheduler: forwarding, load-use/branch resolution, and a
// data-memory wait FSM with timeout, plus a saturating stall-cycle counter.
module hazard_scheduler #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int CNT_WIDTH     = 32,
    parameter int MAX_WAIT      = 16
) (
    input logic              CLK,
    input logic              RST,
    hazard_scheduler_if.slave hz
);
    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;
    localparam int         WW     = $clog2(MAX_WAIT + 1);

    logic [1:0]           state_q, state_d;
    logic [WW-1:0]        wcnt_q, wcnt_d;
    logic                 to_q, to_d;
    logic [CNT_WIDTH-1:0] cyc_q, cyc_d;

    logic mem_stall, load_use;
    logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
    logic [1:0] fwd_a, fwd_b;

    function automatic logic [1:0] fwd_sel(input logic [ADDRESS_WIDTH-1:0] rs);
        if (hz.RegWriteM && hz.RdM != '0 && hz.RdM == rs)      fwd_sel = 2'b10;
        else if (hz.RegWriteW && hz.RdW != '0 && hz.RdW == rs) fwd_sel = 2'b01;
        else                                                  fwd_sel = 2'b00;
    endfunction

    assign load_use  = (hz.ResultSrcE == 2'b01) && (hz.RdE != '0) &&
                       ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
    assign mem_stall = (state_q == S_WAIT) || (state_q == S_ERR) ||
                       (state_q == S_RUN && hz.DMemReq && !hz.DMemReady);

    always_comb begin
        stall_f = 1'b0; stall_d = 1'b0; stall_e = 1'b0; stall_m = 1'b0;
        flush_d = 1'b0; flush_e = 1'b0; flush_w = 1'b0;
        fwd_a   = 2'b00; fwd_b  = 2'b00;
        if (RST) begin
            flush_d = 1'b1; flush_e = 1'b1; flush_w = 1'b1;
        end else begin
            fwd_a = fwd_sel(hz.Rs1E);
            fwd_b = fwd_sel(hz.Rs2E);
            // A taken branch stays parked in the stalled E register until memory releases.
            if (mem_stall) begin
                stall_f = 1'b1; stall_d = 1'b1; stall_e = 1'b1; stall_m = 1'b1;
                flush_w = 1'b1;
            end else if (hz.PCSrcE) begin
                flush_d = 1'b1; flush_e = 1'b1;
            end else if (load_use) begin
                stall_f = 1'b1; stall_d = 1'b1; flush_e = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        to_d    = to_q;
        cyc_d   = (stall_f && cyc_q != '1) ? cyc_q + 1'b1 : cyc_q;
        case (state_q)
            S_RUN: if (hz.DMemReq && !hz.DMemReady) begin
                state_d = S_WAIT;
                wcnt_d  = WW'(1);
            end
            S_WAIT: if (hz.DMemReady) begin
                state_d = S_RUN;
                wcnt_d  = '0;
            end else if (wcnt_q == WW'(MAX_WAIT - 1)) begin
                state_d = S_ERR;
                to_d    = 1'b1;
            end else begin
                wcnt_d  = wcnt_q + 1'b1;
            end
            default: state_d = S_ERR;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_RUN;
            wcnt_q  <= '0;
            to_q    <= 1'b0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            to_q    <= to_d;
            cyc_q   <= cyc_d;
        end
    end

    assign hz.StallF      = stall_f;
    assign hz.StallD      = stall_d;
    assign hz.StallE      = stall_e;
    assign hz.StallM      = stall_m;
    assign hz.FlushD      = flush_d;
    assign hz.FlushE      = flush_e;
    assign hz.FlushW      = flush_w;
    assign hz.ForwardAE   = fwd_a;
    assign hz.ForwardBE   = fwd_b;
    assign hz.MemTimeout  = to_q;
    assign hz.StallCycles = cyc_q;
endmodule

// File: tb/tb_hazard_scheduler.sv
// Scoreboard bench for hazard_scheduler: expected controls are queued when a cycle is
// driven and compared at the following negedge.
module tb_hazard_scheduler;
    localparam int AW = 5;
    localparam int CW = 4;
    localparam int MW = 16;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    hazard_scheduler_if #(.AW(AW), .CW(CW)) hz ();

    hazard_scheduler #(.ADDRESS_WIDTH(AW), .CNT_WIDTH(CW), .MAX_WAIT(MW)) dut (
        .CLK (CLK),
        .RST (RST),
        .hz  (hz)
    );

    typedef struct packed {
        logic          rst;
        logic [AW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic          rwm, rww;
        logic [1:0]    rsrc;
        logic          pcsrc, req, rdy;
    } stim_t;

    typedef struct packed {
        logic          sf, sd, se, sm, fd, fe, fw;
        logic [1:0]    fa, fb;
        logic          to;
        logic [CW-1:0] cyc;
    } exp_t;

    exp_t    exp_q[$];
    int      n_chk = 0;
    int      n_fail = 0;

    // reference state
    int            m_st = 0;   // 0 run, 1 wait, 2 error
    int            m_wc = 0;
    logic          m_to = 1'b0;
    logic [CW-1:0] m_cyc = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input stim_t s, input logic [AW-1:0] rs);
        if (s.rwm && s.rdm != 0 && s.rdm == rs) return 2'b10;
        if (s.rww && s.rdw != 0 && s.rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic exp_t ref_out(input stim_t s);
        exp_t e;
        logic ms, lu;
        e     = '0;
        e.to  = m_to;
        e.cyc = m_cyc;
        if (s.rst) begin
            e.fd = 1'b1; e.fe = 1'b1; e.fw = 1'b1;
            return e;
        end
        e.fa = ref_fwd(s, s.rs1e);
        e.fb = ref_fwd(s, s.rs2e);
        ms = (m_st != 0) || (s.req && !s.rdy);
        lu = (s.rsrc == 2'b01) && s.rde != 0 && (s.rde == s.rs1d || s.rde == s.rs2d);
        if (ms)           {e.sf, e.sd, e.se, e.sm, e.fw} = 5'b11111;
        else if (s.pcsrc) {e.fd, e.fe} = 2'b11;
        else if (lu)      {e.sf, e.sd, e.fe} = 3'b111;
        return e;
    endfunction

    task automatic drive(input stim_t s);
        exp_t e, g;
        RST = s.rst;
        hz.Rs1D = s.rs1d; hz.Rs2D = s.rs2d; hz.Rs1E = s.rs1e; hz.Rs2E = s.rs2e;
        hz.RdE = s.rde; hz.RdM = s.rdm; hz.RdW = s.rdw;
        hz.RegWriteM = s.rwm; hz.RegWriteW = s.rww; hz.ResultSrcE = s.rsrc;
        hz.PCSrcE = s.pcsrc; hz.DMemReq = s.req; hz.DMemReady = s.rdy;
        e = ref_out(s);
        exp_q.push_back(e);
        @(negedge CLK);
        chk("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            g = exp_q.pop_front();
            chk("StallF", 32'(hz.StallF), 32'(g.sf));
            chk("StallD", 32'(hz.StallD), 32'(g.sd));
            chk("StallE", 32'(hz.StallE), 32'(g.se));
            chk("StallM", 32'(hz.StallM), 32'(g.sm));
            chk("FlushD", 32'(hz.FlushD), 32'(g.fd));
            chk("FlushE", 32'(hz.FlushE), 32'(g.fe));
            chk("FlushW", 32'(hz.FlushW), 32'(g.fw));
            chk("ForwardAE", 32'(hz.ForwardAE), 32'(g.fa));
            chk("ForwardBE", 32'(hz.ForwardBE), 32'(g.fb));
            chk("MemTimeout", 32'(hz.MemTimeout), 32'(g.to));
            chk("StallCycles", 32'(hz.StallCycles), 32'(g.cyc));
        end
        @(posedge CLK);
        if (s.rst) begin
            m_st = 0; m_wc = 0; m_to = 1'b0; m_cyc = '0;
        end else begin
            if (e.sf && m_cyc != 4'hF) m_cyc = m_cyc + 1'b1;
            if (m_st == 0) begin
                if (s.req && !s.rdy) begin m_st = 1; m_wc = 1; end
            end else if (m_st == 1) begin
                if (s.rdy)              begin m_st = 0; m_wc = 0; end
                else if (m_wc == MW - 1) begin m_st = 2; m_to = 1'b1; end
                else                    m_wc++;
            end
        end
        #1;
    endtask

    stim_t s;

    initial begin
        s = '0; s.rst = 1'b1;
        RST = 1'b1;
        @(posedge CLK); #1;
        drive(s); drive(s);

        // forwarding: M beats W, x0 never forwarded
        s = '0; s.rwm = 1; s.rdm = 5; s.rww = 1; s.rdw = 5; s.rs1e = 5; s.rs2e = 5;
        drive(s);
        s.rdm = 7;  drive(s);
        s.rdm = 0; s.rdw = 0; drive(s);
        s.rwm = 0; s.rdm = 5; s.rdw = 5; s.rww = 1; s.rs1e = 5; s.rs2e = 9; drive(s);

        // load-use single bubble, then release
        s = '0; s.rsrc = 2'b01; s.rde = 3; s.rs2d = 3; drive(s);
        s = '0; drive(s);
        s.rsrc = 2'b01; s.rde = 0; drive(s);

        // branch overrides load-use
        s = '0; s.rsrc = 2'b01; s.rde = 4; s.rs1d = 4; s.pcsrc = 1; drive(s);
        s = '0; drive(s);

        // memory wait of 3 cycles then ready, branch held under stall
        s = '0; s.req = 1; s.pcsrc = 1;
        repeat (3) drive(s);
        s.rdy = 1; drive(s);
        s = '0; drive(s);

        // random hazards with no memory traffic
        for (int i = 0; i < 20; i++) begin
            s = '0;
            s.rs1d = AW'($urandom_range(0, 7)); s.rs2d = AW'($urandom_range(0, 7));
            s.rs1e = AW'($urandom_range(0, 7)); s.rs2e = AW'($urandom_range(0, 7));
            s.rde  = AW'($urandom_range(0, 7)); s.rdm  = AW'($urandom_range(0, 7));
            s.rdw  = AW'($urandom_range(0, 7));
            s.rwm = 1'($urandom); s.rww = 1'($urandom);
            s.rsrc = 2'($urandom); s.pcsrc = ($urandom_range(0, 3) == 0);
            drive(s);
        end

        // timeout: ready never arrives, then illegal req drop while in error
        s = '0; s.req = 1;
        repeat (MW + 4) drive(s);
        s.req = 0; repeat (4) drive(s);

        // reset out of error clears everything
        s = '0; s.rst = 1; drive(s);
        s = '0; drive(s);
        s.req = 1; drive(s);
        s.rst = 1; drive(s);
        s = '0; drive(s);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
